pipe_control: RTL and testbench
===============================

// Module: pipe_control
// PURPOSE
//  Pipelined main control for the 5-stage MIPS datapath: decodes opcode/funct in ID and carries the control bundle ID/EX -> EX/MEM -> MEM/WB.
//  Drives per-stage RegDst/ALUSrc/ALUOp (EX), MemRead/MemWrite/Branch (MEM) and RegWrite/MemtoReg (WB) into the datapath.
//  Also detects load-use hazards, inserts bubbles, honours branch flush, and counts stall cycles.
// PARAMETERS
//  OPC_W      6   opcode width, equals `OPCODE_WIDTH
//  FUNCT_W    6   funct field width
//  AWIDTH     5   register-address width
//  CNT_W      16  stall-counter width
// PORTS
//  c_clk          in   1        clock, all state on rising edge
//  c_rst          in   1        asynchronous reset, active-low
//  c_i_ce         in   1        pipeline advance enable; 0 = hold every register
//  c_i_opcode     in   OPC_W    opcode of instruction in ID
//  c_i_funct      in   FUNCT_W  funct of instruction in ID
//  c_i_rs         in   AWIDTH   rs of instruction in ID
//  c_i_rt         in   AWIDTH   rt of instruction in ID
//  c_i_flush      in   1        branch taken, resolved in MEM
//  c_o_stall      out  1        load-use stall: hold PC and IF/ID
//  c_o_illegal    out  1        ID opcode unsupported (combinational)
//  c_o_ex_RegDst, c_o_ex_ALUSrc   out 1 each   EX-stage controls
//  c_o_ex_ALUOp   out  2        00 add, 01 sub, 10 use funct
//  c_o_ex_funct   out  FUNCT_W  funct carried with bundle
//  c_o_mem_MemRead, c_o_mem_MemWrite, c_o_mem_Branch   out 1 each
//  c_o_wb_RegWrite, c_o_wb_MemtoReg                     out 1 each
//  c_o_stall_cnt  out  CNT_W    saturating count of stall cycles
// BEHAVIOUR
//  Reset (c_rst=0, async): all pipeline regs, outputs and counter = 0 (bubble).
//  Decode (combinational, ID). RD=RegDst, RW=RegWrite, AS=ALUSrc, MR=MemRead, MW=MemWrite, M2R=MemtoReg, BR=Branch:
//   000000 R-type:  RD=1 RW=1 AS=0 ALUOp=10
//   100011 lw:      AS=1 MR=1 RW=1 M2R=1 ALUOp=00
//   101011 sw:      AS=1 MW=1 ALUOp=00
//   000100 beq:     BR=1 ALUOp=01
//   001000 addi:    AS=1 RW=1 ALUOp=00
//   other:          all 0, c_o_illegal=1; bundle enters pipe as bubble
//  Pipeline: on rising edge with c_i_ce=1: ID/EX <= decoded bundle (plus rt as ex_rt),
//   EX/MEM <= ID/EX, MEM/WB <= EX/MEM. Stage outputs come straight from regs.
//   Latency opcode->EX outputs 1 cycle, ->MEM 2, ->WB 3.
//  Hazard (combinational): stall = ex_MemRead & ex_rt!=0 & (ex_rt==c_i_rs | (ex_rt==c_i_rt & ID uses rt)).
//   ID uses rt for R-type, sw, beq. Stall loads a bubble into ID/EX; downstream still advances.
//   Stall is not asserted when c_i_ce=0.
//  Flush: c_i_flush=1 with ce -> ID/EX and EX/MEM load bubbles; MEM/WB advances normally.
//   Flush has priority over stall. Stall still reports the combinational value.
//  c_i_ce=0: all regs hold, counter holds, flush ignored.
//  Counter: +1 each ce cycle with stall=1; saturates at 2^CNT_W-1, no wrap.
//  Bubble: every control bit 0, ALUOp=00, funct=0, rt=0.
// STRUCTURE
//  Shared pkg/header (mips_defines): `OPCODE_WIDTH, opcode constants (OP_RTYPE, OP_LW,
//   OP_SW, OP_BEQ, OP_ADDI), ALUOp encodings, control-bundle field widths.
//  One sub-module: ctrl_decoder (pure combinational opcode->bundle + illegal). Pipeline regs,
//   hazard logic and counter are inline.
// TESTING
//  1 Reset: c_rst=0 mid-run -> all outputs 0 immediately, asynchronously; counter 0.
//  2 R-type 000000 then idle: EX RegDst=1 ALUOp=10 at +1; wb_RegWrite=1 at +3, MemtoReg=0.
//  3 lw rt=5 then add rs=5: stall=1 for exactly 1 cycle; EX bubble on the next cycle; stall_cnt=1;
//    the add reaches EX one cycle late.
//  4 lw rt=0 then add rs=0: no stall. sw after lw with matching rt: stall=1.
//  5 beq in MEM with flush=1 while lw-use stall is pending: ID/EX and EX/MEM are both
//    bubbles next cycle; MEM/WB holds the older instruction's controls.
//  6 Illegal opcode 111111 -> illegal=1, bubble propagates. ce=0 for 3 cycles -> outputs frozen.
//    Forced 65535 stalls -> counter holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_control_pkg.sv
// Shared definitions for the pipelined MIPS main control: opcodes, ALUOp encodings
// and the per-stage control bundles carried down the pipeline.
package pipe_control_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int ALUOP_W      = 2;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        aluop_e alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_bundle_t;

endpackage

// File: rtl/pipe_control_ctrl_decoder.sv
// Combinational ID-stage decoder: opcode -> control bundle, rt-usage and illegal flag.
// Unsupported opcodes decode to an all-zero bundle so they enter the pipe as bubbles.
module ctrl_decoder
    import pipe_control_pkg::*;
#(
    parameter int OPC_W = OPCODE_WIDTH
) (
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_bundle_t     ctrl_o,
    output logic             uses_rt_o,
    output logic             illegal_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.ex.alu_op = ALUOP_ADD;
        uses_rt_o        = 1'b0;
        illegal_o        = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.ex.reg_dst   = 1'b1;
                ctrl_o.ex.alu_op    = ALUOP_FUNCT;
                ctrl_o.wb.reg_write = 1'b1;
                uses_rt_o           = 1'b1;
            end
            OP_LW: begin
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.mem.mem_read  = 1'b1;
                ctrl_o.wb.reg_write  = 1'b1;
                ctrl_o.wb.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.mem.mem_write = 1'b1;
                uses_rt_o            = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.ex.alu_op  = ALUOP_SUB;
                ctrl_o.mem.branch = 1'b1;
                uses_rt_o         = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipelined main control: decodes in ID, carries controls through ID/EX, EX/MEM, MEM/WB,
// detects load-use hazards, honours branch flush and counts stall cycles.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int OPC_W   = OPCODE_WIDTH,
    parameter int FUNCT_W = 6,
    parameter int AWIDTH  = 5,
    parameter int CNT_W   = 16
) (
    input  logic               c_clk,
    input  logic               c_rst,
    input  logic               c_i_ce,
    input  logic [OPC_W-1:0]   c_i_opcode,
    input  logic [FUNCT_W-1:0] c_i_funct,
    input  logic [AWIDTH-1:0]  c_i_rs,
    input  logic [AWIDTH-1:0]  c_i_rt,
    input  logic               c_i_flush,
    output logic               c_o_stall,
    output logic               c_o_illegal,
    output logic               c_o_ex_RegDst,
    output logic               c_o_ex_ALUSrc,
    output logic [1:0]         c_o_ex_ALUOp,
    output logic [FUNCT_W-1:0] c_o_ex_funct,
    output logic               c_o_mem_MemRead,
    output logic               c_o_mem_MemWrite,
    output logic               c_o_mem_Branch,
    output logic               c_o_wb_RegWrite,
    output logic               c_o_wb_MemtoReg,
    output logic [CNT_W-1:0]   c_o_stall_cnt
);

    ctrl_bundle_t       dec_ctrl;
    logic               dec_uses_rt;
    logic               dec_illegal;

    ctrl_bundle_t       id_ex_q,       id_ex_d;
    logic [FUNCT_W-1:0] id_ex_funct_q, id_ex_funct_d;
    logic [AWIDTH-1:0]  id_ex_rt_q,    id_ex_rt_d;
    mem_ctrl_t          ex_mem_mem_q,  ex_mem_mem_d;
    wb_ctrl_t           ex_mem_wb_q,   ex_mem_wb_d;
    wb_ctrl_t           mem_wb_q,      mem_wb_d;
    logic [CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;
    logic               stall;

    ctrl_decoder #(
        .OPC_W (OPC_W)
    ) u_decoder (
        .opcode_i  (c_i_opcode),
        .ctrl_o    (dec_ctrl),
        .uses_rt_o (dec_uses_rt),
        .illegal_o (dec_illegal)
    );

    // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
    assign stall = c_i_ce & id_ex_q.mem.mem_read & (id_ex_rt_q != '0)
                 & ((id_ex_rt_q == c_i_rs) | ((id_ex_rt_q == c_i_rt) & dec_uses_rt));

    always_comb begin
        id_ex_d       = id_ex_q;
        id_ex_funct_d = id_ex_funct_q;
        id_ex_rt_d    = id_ex_rt_q;
        ex_mem_mem_d  = ex_mem_mem_q;
        ex_mem_wb_d   = ex_mem_wb_q;
        mem_wb_d      = mem_wb_q;
        stall_cnt_d   = stall_cnt_q;
        if (c_i_ce) begin
            mem_wb_d = ex_mem_wb_q;
            if (c_i_flush) begin
                id_ex_d       = '0;
                id_ex_funct_d = '0;
                id_ex_rt_d    = '0;
                ex_mem_mem_d  = '0;
                ex_mem_wb_d   = '0;
            end else begin
                ex_mem_mem_d = id_ex_q.mem;
                ex_mem_wb_d  = id_ex_q.wb;
                if (stall || dec_illegal) begin
                    id_ex_d       = '0;
                    id_ex_funct_d = '0;
                    id_ex_rt_d    = '0;
                end else begin
                    id_ex_d       = dec_ctrl;
                    id_ex_funct_d = c_i_funct;
                    id_ex_rt_d    = c_i_rt;
                end
            end
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            id_ex_q       <= '0;
            id_ex_funct_q <= '0;
            id_ex_rt_q    <= '0;
            ex_mem_mem_q  <= '0;
            ex_mem_wb_q   <= '0;
            mem_wb_q      <= '0;
            stall_cnt_q   <= '0;
        end else begin
            id_ex_q       <= id_ex_d;
            id_ex_funct_q <= id_ex_funct_d;
            id_ex_rt_q    <= id_ex_rt_d;
            ex_mem_mem_q  <= ex_mem_mem_d;
            ex_mem_wb_q   <= ex_mem_wb_d;
            mem_wb_q      <= mem_wb_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign c_o_stall        = stall;
    assign c_o_illegal      = dec_illegal;
    assign c_o_ex_RegDst    = id_ex_q.ex.reg_dst;
    assign c_o_ex_ALUSrc    = id_ex_q.ex.alu_src;
    assign c_o_ex_ALUOp     = id_ex_q.ex.alu_op;
    assign c_o_ex_funct     = id_ex_funct_q;
    assign c_o_mem_MemRead  = ex_mem_mem_q.mem_read;
    assign c_o_mem_MemWrite = ex_mem_mem_q.mem_write;
    assign c_o_mem_Branch   = ex_mem_mem_q.branch;
    assign c_o_wb_RegWrite  = mem_wb_q.reg_write;
    assign c_o_wb_MemtoReg  = mem_wb_q.mem_to_reg;
    assign c_o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed scenarios plus random traffic, checked against an
// instruction-level pipeline model (which instruction sits in EX/MEM/WB, and what it implies).
module tb_pipe_control;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam bit [5:0] R    = 6'h00;
    localparam bit [5:0] LW   = 6'h23;
    localparam bit [5:0] SW   = 6'h2B;
    localparam bit [5:0] BEQ  = 6'h04;
    localparam bit [5:0] ADDI = 6'h08;
    localparam bit [5:0] BAD  = 6'h3F;

    logic             c_clk = 1'b0;
    logic             c_rst;
    logic             c_i_ce;
    logic [5:0]       c_i_opcode;
    logic [5:0]       c_i_funct;
    logic [4:0]       c_i_rs;
    logic [4:0]       c_i_rt;
    logic             c_i_flush;
    logic             c_o_stall;
    logic             c_o_illegal;
    logic             c_o_ex_RegDst;
    logic             c_o_ex_ALUSrc;
    logic [1:0]       c_o_ex_ALUOp;
    logic [5:0]       c_o_ex_funct;
    logic             c_o_mem_MemRead;
    logic             c_o_mem_MemWrite;
    logic             c_o_mem_Branch;
    logic             c_o_wb_RegWrite;
    logic             c_o_wb_MemtoReg;
    logic [CNT_W-1:0] c_o_stall_cnt;

    pipe_control #(
        .OPC_W   (6),
        .FUNCT_W (6),
        .AWIDTH  (5),
        .CNT_W   (CNT_W)
    ) dut (
        .c_clk            (c_clk),
        .c_rst            (c_rst),
        .c_i_ce           (c_i_ce),
        .c_i_opcode       (c_i_opcode),
        .c_i_funct        (c_i_funct),
        .c_i_rs           (c_i_rs),
        .c_i_rt           (c_i_rt),
        .c_i_flush        (c_i_flush),
        .c_o_stall        (c_o_stall),
        .c_o_illegal      (c_o_illegal),
        .c_o_ex_RegDst    (c_o_ex_RegDst),
        .c_o_ex_ALUSrc    (c_o_ex_ALUSrc),
        .c_o_ex_ALUOp     (c_o_ex_ALUOp),
        .c_o_ex_funct     (c_o_ex_funct),
        .c_o_mem_MemRead  (c_o_mem_MemRead),
        .c_o_mem_MemWrite (c_o_mem_MemWrite),
        .c_o_mem_Branch   (c_o_mem_Branch),
        .c_o_wb_RegWrite  (c_o_wb_RegWrite),
        .c_o_wb_MemtoReg  (c_o_wb_MemtoReg),
        .c_o_stall_cnt    (c_o_stall_cnt)
    );

    always #5 c_clk = ~c_clk;

    // Model: the instruction occupying each stage (valid=0 means bubble).
    typedef struct {
        bit       valid;
        bit [5:0] op;
        bit [5:0] funct;
        bit [4:0] rt;
    } inst_t;

    localparam inst_t BUBBLE = '{valid: 1'b0, op: 6'h0, funct: 6'h0, rt: 5'h0};

    inst_t       m_ex, m_mem, m_wb;
    int unsigned m_cnt;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    bit          verbose = 1'b1;

    function automatic bit is_legal(bit [5:0] op);
        return (op == R) || (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI);
    endfunction

    function automatic bit reads_rt(bit [5:0] op);
        return (op == R) || (op == SW) || (op == BEQ);
    endfunction

    // {RegDst, ALUSrc, ALUOp}
    function automatic bit [3:0] exp_ex(inst_t i);
        if (!i.valid) return 4'b0000;
        case (i.op)
            R:       return 4'b1010;
            LW, SW:  return 4'b0100;
            BEQ:     return 4'b0001;
            ADDI:    return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    // {MemRead, MemWrite, Branch}
    function automatic bit [2:0] exp_mem(inst_t i);
        return i.valid ? {i.op == LW, i.op == SW, i.op == BEQ} : 3'b000;
    endfunction

    // {RegWrite, MemtoReg}
    function automatic bit [1:0] exp_wb(inst_t i);
        return i.valid ? {(i.op == R) || (i.op == LW) || (i.op == ADDI), i.op == LW} : 2'b00;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex  = BUBBLE;
        m_mem = BUBBLE;
        m_wb  = BUBBLE;
        m_cnt = 0;
    endtask

    task automatic chk_stages(string tag);
        chk({tag, "_ex"},    {c_o_ex_RegDst, c_o_ex_ALUSrc, c_o_ex_ALUOp}, exp_ex(m_ex));
        chk({tag, "_funct"}, c_o_ex_funct, m_ex.valid ? m_ex.funct : 6'h0);
        chk({tag, "_mem"},   {c_o_mem_MemRead, c_o_mem_MemWrite, c_o_mem_Branch}, exp_mem(m_mem));
        chk({tag, "_wb"},    {c_o_wb_RegWrite, c_o_wb_MemtoReg}, exp_wb(m_wb));
        chk({tag, "_cnt"},   c_o_stall_cnt, m_cnt);
    endtask

    // One transaction: called at a falling edge, returns at the next falling edge.
    task automatic step(bit ce, bit [5:0] op, bit [5:0] fn, bit [4:0] rs, bit [4:0] rt, bit fl);
        bit exp_stall;
        c_i_ce     = ce;
        c_i_opcode = op;
        c_i_funct  = fn;
        c_i_rs     = rs;
        c_i_rt     = rt;
        c_i_flush  = fl;
        #1;
        exp_stall = ce && m_ex.valid && (m_ex.op == LW) && (m_ex.rt != 0)
                 && ((m_ex.rt == rs) || ((m_ex.rt == rt) && reads_rt(op)));
        chk("stall",   c_o_stall,   exp_stall);
        chk("illegal", c_o_illegal, !is_legal(op));
        @(posedge c_clk);
        if (ce) begin
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            m_wb = m_mem;
            if (fl) begin
                m_mem = BUBBLE;
                m_ex  = BUBBLE;
            end else begin
                m_mem = m_ex;
                m_ex  = (exp_stall || !is_legal(op)) ? BUBBLE
                      : '{valid: 1'b1, op: op, funct: fn, rt: rt};
            end
        end
        #1;
        chk_stages("pipe");
        if (verbose)
            $display("t=%0t ce=%0b op=%02h fn=%02h rs=%0d rt=%0d flush=%0b stall=%0b cnt=%0d",
                     $time, ce, op, fn, rs, rt, fl, exp_stall, m_cnt);
        @(negedge c_clk);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_stall"}, c_o_stall, 1'b0);
        chk({tag, "_ex"},    {c_o_ex_RegDst, c_o_ex_ALUSrc, c_o_ex_ALUOp, c_o_ex_funct}, 0);
        chk({tag, "_mem"},   {c_o_mem_MemRead, c_o_mem_MemWrite, c_o_mem_Branch}, 0);
        chk({tag, "_wb"},    {c_o_wb_RegWrite, c_o_wb_MemtoReg}, 0);
        chk({tag, "_cnt"},   c_o_stall_cnt, 0);
    endtask

    initial begin
        bit [5:0] ops [5] = '{R, LW, SW, BEQ, ADDI};
        bit [5:0] rop;

        c_rst = 1'b0; c_i_ce = 1'b0; c_i_opcode = R; c_i_funct = '0;
        c_i_rs = '0; c_i_rt = '0; c_i_flush = 1'b0;
        model_reset();
        repeat (2) @(negedge c_clk);
        chk_all_zero("reset");
        c_rst = 1'b1;
        @(negedge c_clk);

        // R-type then idle: EX at +1, WB at +3
        step(1, R, 6'h20, 5'd1, 5'd2, 0);
        chk("rtype_ex_regdst", c_o_ex_RegDst, 1'b1);
        chk("rtype_ex_aluop",  c_o_ex_ALUOp, 2'b10);
        step(1, R, 6'h00, 5'd0, 5'd0, 0);
        step(1, R, 6'h00, 5'd0, 5'd0, 0);
        chk("rtype_wb", {c_o_wb_RegWrite, c_o_wb_MemtoReg}, 2'b10);

        // lw rt=5 then add rs=5: one stall cycle, add lands in EX one cycle late
        step(1, LW, 6'h00, 5'd1, 5'd5, 0);
        step(1, R, 6'h20, 5'd5, 5'd6, 0);
        chk("lu_bubble_ex", {c_o_ex_RegDst, c_o_ex_ALUSrc, c_o_ex_ALUOp}, 4'b0000);
        chk("lu_cnt", c_o_stall_cnt, 1);
        step(1, R, 6'h20, 5'd5, 5'd6, 0);
        chk("lu_add_late", {c_o_ex_RegDst, c_o_ex_ALUOp}, 3'b110);
        chk("lu_one_stall", c_o_stall_cnt, 1);

        // lw to r0 never stalls; sw reading a loaded rt does
        step(1, LW, 6'h00, 5'd1, 5'd0, 0);
        step(1, R, 6'h20, 5'd0, 5'd0, 0);
        step(1, LW, 6'h00, 5'd2, 5'd7, 0);
        step(1, SW, 6'h00, 5'd1, 5'd7, 0);
        step(1, SW, 6'h00, 5'd1, 5'd7, 0);

        // flush from a beq in MEM overrides a pending load-use stall
        step(1, ADDI, 6'h00, 5'd0, 5'd3, 0);
        step(1, BEQ, 6'h00, 5'd1, 5'd2, 0);
        step(1, LW, 6'h00, 5'd1, 5'd5, 0);
        step(1, R, 6'h20, 5'd5, 5'd9, 1);
        chk("flush_ex",  {c_o_ex_RegDst, c_o_ex_ALUSrc, c_o_ex_ALUOp}, 4'b0000);
        chk("flush_mem", {c_o_mem_MemRead, c_o_mem_MemWrite, c_o_mem_Branch}, 3'b000);
        step(1, R, 6'h20, 5'd5, 5'd9, 0);

        // illegal opcode becomes a bubble; ce=0 freezes everything and ignores flush
        step(1, BAD, 6'h15, 5'd1, 5'd2, 0);
        step(1, ADDI, 6'h00, 5'd1, 5'd4, 0);
        step(1, LW, 6'h00, 5'd1, 5'd5, 0);
        repeat (3) step(0, R, 6'h20, 5'd5, 5'd5, 1);
        step(1, R, 6'h20, 5'd5, 5'd5, 0);
        step(1, R, 6'h20, 5'd5, 5'd5, 0);

        // random traffic on a small register range so hazards are frequent
        for (int k = 0; k < 300; k++) begin
            rop = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
            step($urandom_range(0, 9) != 0, rop, 6'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
        end

        // saturate the stall counter with back-to-back dependent loads
        verbose = 1'b0;
        for (int k = 0; k < 2 * (CNT_MAX + 1) + 8; k++) step(1, LW, 6'h00, 5'd5, 5'd5, 0);
        verbose = 1'b1;
        chk("cnt_saturated", c_o_stall_cnt, CNT_MAX);
        step(1, LW, 6'h00, 5'd5, 5'd5, 0);
        step(1, LW, 6'h00, 5'd5, 5'd5, 0);
        chk("cnt_holds", c_o_stall_cnt, CNT_MAX);

        // asynchronous reset mid-cycle with a load in flight
        step(1, LW, 6'h00, 5'd1, 5'd5, 0);
        #2;
        c_rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge c_clk);
        c_rst = 1'b1;
        step(1, R, 6'h20, 5'd5, 5'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
